// File: rtl/audio_adc_pkg.sv
// Shared types and helpers for the MCP3202 audio sampler.
//   state_t    : per-channel frame phase plus PUBLISH (debug visibility)
//   seq_t      : top-level channel sequencer state
//   adc_to_pcm : 12-bit offset-binary ADC code -> signed 16-bit PCM
package audio_adc_pkg;

  typedef enum logic [2:0] {IDLE, SETUP, SHIFT, GAP, PUBLISH} state_t;
  typedef enum logic [1:0] {SEQ_IDLE, SEQ_CH0, SEQ_CH1, SEQ_PUBLISH} seq_t;

  localparam int FRAME_BITS = 17;  // sclk periods per channel frame
  localparam int CMD_BITS   = 4;   // start, sgl/diff, odd/sign, msbf
  localparam int NULL_BIT   = 4;   // ADC drives a null bit here
  localparam int ADC_BITS   = 12;

  // Mid-scale (0x800) maps to zero; flipping the MSB turns offset binary
  // into two's complement, then the 12 bits are left-justified in 16.
  function automatic logic [15:0] adc_to_pcm(input logic [ADC_BITS-1:0] code);
    return {~code[ADC_BITS-1], code[ADC_BITS-2:0], 4'b0000};
  endfunction

endpackage

// File: rtl/mcp3202_frame.sv
// One MCP3202 channel conversion frame: CS low, 17 SPI clocks, CS high gap.
// Ports:
//   clk, reset   : clock, synchronous active-high reset
//   start, ch    : begin a frame for channel ch (honoured in IDLE or the
//                  last GAP cycle, so back-to-back frames keep exact timing)
//   miso         : already-synchronised ADC data
//   done         : high in the last GAP cycle; code is valid while high
//   code         : 12-bit conversion result, MSB first from the ADC
//   sclk/cs/mosi : SPI pins (sclk idles low, cs active low)
//   phase        : current frame phase, for debug
module mcp3202_frame
  import audio_adc_pkg::*;
#(
  parameter int SCLK_HALF = 14,
  parameter int CS_IDLE   = 14
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                start,
  input  logic                ch,
  input  logic                miso,
  output logic                done,
  output logic [ADC_BITS-1:0] code,
  output logic                sclk,
  output logic                cs,
  output logic                mosi,
  output state_t              phase
);

  localparam int CNT_MAX = (2 * SCLK_HALF > CS_IDLE) ? 2 * SCLK_HALF : CS_IDLE;
  localparam int CNT_W   = $clog2(CNT_MAX);

  localparam logic [CNT_W-1:0] HALF_LAST   = CNT_W'(SCLK_HALF - 1);
  localparam logic [CNT_W-1:0] PERIOD_LAST = CNT_W'(2 * SCLK_HALF - 1);
  localparam logic [CNT_W-1:0] GAP_LAST    = CNT_W'(CS_IDLE - 1);
  localparam logic [4:0]       LAST_BIT    = 5'(FRAME_BITS - 1);
  localparam logic [4:0]       FIRST_DATA  = 5'(NULL_BIT + 1);

  logic [CNT_W-1:0] cnt;
  logic [4:0]       bit_idx;
  logic             ch_r;

  // Command word: start, single-ended, channel select, MSB-first; then zeros.
  function automatic logic cmd_bit(input logic [4:0] idx, input logic odd);
    if (idx >= 5'(CMD_BITS)) cmd_bit = 1'b0;
    else if (idx == 5'd2)    cmd_bit = odd;
    else                     cmd_bit = 1'b1;
  endfunction

  assign done = (phase == GAP) && (cnt == GAP_LAST);

  always_ff @(posedge clk) begin
    if (reset) begin
      phase   <= IDLE;
      cnt     <= '0;
      bit_idx <= '0;
      ch_r    <= 1'b0;
      code    <= '0;
      sclk    <= 1'b0;
      cs      <= 1'b1;
      mosi    <= 1'b0;
    end else begin
      cnt <= cnt + 1'b1;
      case (phase)
        IDLE: begin
          cnt <= '0;
          if (start) begin
            phase <= SETUP;
            cs    <= 1'b0;
            ch_r  <= ch;
            mosi  <= 1'b1;
            code  <= '0;
          end
        end
        SETUP: begin
          if (cnt == HALF_LAST) begin
            phase   <= SHIFT;
            cnt     <= '0;
            bit_idx <= '0;
          end
        end
        SHIFT: begin
          // mosi moves one cycle into the low phase, never next to an sclk edge.
          if (cnt == '0) mosi <= cmd_bit(bit_idx, ch_r);
          if (cnt == HALF_LAST) sclk <= 1'b1;
          if (cnt == PERIOD_LAST) begin
            // Last cycle of the high phase: sample, then drop sclk.
            sclk <= 1'b0;
            cnt  <= '0;
            if (bit_idx >= FIRST_DATA) code <= {code[ADC_BITS-2:0], miso};
            if (bit_idx == LAST_BIT) begin
              phase <= GAP;
              cs    <= 1'b1;
            end else begin
              bit_idx <= bit_idx + 1'b1;
            end
          end
        end
        GAP: begin
          if (cnt == GAP_LAST) begin
            cnt <= '0;
            if (start) begin
              phase <= SETUP;
              cs    <= 1'b0;
              ch_r  <= ch;
              mosi  <= 1'b1;
              code  <= '0;
            end else begin
              phase <= IDLE;
            end
          end
        end
        default: phase <= IDLE;
      endcase
    end
  end

endmodule

// File: rtl/adc_audio_sampler.sv
// MCP3202 stereo sampler: a rate counter triggers a CH0 then CH1 conversion,
// and both results are published together as signed 16-bit PCM.
// Ports:
//   clk, reset         : pixel clock, synchronous active-high reset
//   adc_miso           : ADC data out (asynchronous, synchronised here)
//   adc_clk/cs/mosi    : SPI pins to the ADC
//   audio_sample_word  : [0]=left (CH0), [1]=right (CH1), signed PCM
//   sample_valid       : one-cycle strobe; both words change only in that
//                        cycle and hold until the next strobe. There is no
//                        back-pressure: the consumer must take the words
//                        while they are held.
//   busy               : high from the accepted tick through the strobe cycle
//   overrun            : sticky, a tick arrived while busy (tick dropped)
//   fsm_state          : frame phase, or PUBLISH, for debug
module adc_audio_sampler
  import audio_adc_pkg::*;
#(
  parameter int SAMPLE_DIV = 1125,
  parameter int SCLK_HALF  = 14,
  parameter int CS_IDLE    = 14
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            adc_miso,
  output logic            adc_clk,
  output logic            adc_cs,
  output logic            adc_mosi,
  output logic [1:0][15:0] audio_sample_word,
  output logic            sample_valid,
  output logic            busy,
  output logic            overrun,
  output state_t          fsm_state
);

  localparam int DIV_W = (SAMPLE_DIV > 1) ? $clog2(SAMPLE_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SAMPLE_DIV - 1);

  logic [DIV_W-1:0]    rate_cnt;
  logic                tick;
  logic                miso_meta;
  logic                miso_sync;
  seq_t                seq;
  logic [ADC_BITS-1:0] code0;
  logic [ADC_BITS-1:0] frame_code;
  logic                frame_start;
  logic                frame_ch;
  logic                frame_done;
  state_t              frame_phase;

  assign tick = (rate_cnt == DIV_LAST);

  always_ff @(posedge clk) begin
    if (reset)     rate_cnt <= '0;
    else if (tick) rate_cnt <= '0;
    else           rate_cnt <= rate_cnt + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      miso_meta <= 1'b0;
      miso_sync <= 1'b0;
    end else begin
      miso_meta <= adc_miso;
      miso_sync <= miso_meta;
    end
  end

  // Start is combinational so CH0 begins the cycle after the tick and CH1
  // follows CH0's gap with no dead cycle.
  assign frame_start = ((seq == SEQ_IDLE) && tick) || ((seq == SEQ_CH0) && frame_done);
  assign frame_ch    = (seq == SEQ_CH0);

  mcp3202_frame #(
    .SCLK_HALF (SCLK_HALF),
    .CS_IDLE   (CS_IDLE)
  ) u_frame (
    .clk   (clk),
    .reset (reset),
    .start (frame_start),
    .ch    (frame_ch),
    .miso  (miso_sync),
    .done  (frame_done),
    .code  (frame_code),
    .sclk  (adc_clk),
    .cs    (adc_cs),
    .mosi  (adc_mosi),
    .phase (frame_phase)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      seq               <= SEQ_IDLE;
      code0             <= '0;
      audio_sample_word <= '0;
      sample_valid      <= 1'b0;
      busy              <= 1'b0;
      overrun           <= 1'b0;
    end else begin
      sample_valid <= 1'b0;
      if (tick && (seq != SEQ_IDLE)) overrun <= 1'b1;
      case (seq)
        SEQ_IDLE: begin
          if (tick) begin
            seq  <= SEQ_CH0;
            busy <= 1'b1;
          end
        end
        SEQ_CH0: begin
          if (frame_done) begin
            code0 <= frame_code;
            seq   <= SEQ_CH1;
          end
        end
        SEQ_CH1: begin
          if (frame_done) begin
            audio_sample_word[0] <= adc_to_pcm(code0);
            audio_sample_word[1] <= adc_to_pcm(frame_code);
            sample_valid         <= 1'b1;
            seq                  <= SEQ_PUBLISH;
          end
        end
        SEQ_PUBLISH: begin
          busy <= 1'b0;
          seq  <= SEQ_IDLE;
        end
        default: seq <= SEQ_IDLE;
      endcase
    end
  end

  assign fsm_state = (seq == SEQ_PUBLISH) ? PUBLISH : frame_phase;

endmodule
